// File: rtl/ci_initiator_pkg.sv
// ci_initiator shared types: FSM states, widths, packed command.
// Imported by the interface, the command FIFO and the top.
package ci_initiator_pkg;

  localparam int CI_ID_W = 8;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESPOND
  } state_e;

  typedef struct packed {
    logic [CI_ID_W-1:0] ci_n;
    logic [DATA_W-1:0]  value_a;
    logic [DATA_W-1:0]  value_b;
  } ci_cmd_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ci_initiator_if.sv
// ci_initiator bus bundle: command push, CI bus, response port.
// master = initiator view, slave = producer/responder/consumer view.
interface ci_initiator_if;
  import ci_initiator_pkg::*;

  logic               cmdValid;
  logic               cmdReady;
  logic [CI_ID_W-1:0] cmdCiN;
  logic [DATA_W-1:0]  cmdValueA;
  logic [DATA_W-1:0]  cmdValueB;

  logic               ciStart;
  logic [CI_ID_W-1:0] ciN;
  logic [DATA_W-1:0]  ciValueA;
  logic [DATA_W-1:0]  ciValueB;
  logic               ciDone;
  logic [DATA_W-1:0]  ciResult;

  logic               rspValid;
  logic               rspReady;
  logic [DATA_W-1:0]  rspResult;
  logic [CI_ID_W-1:0] rspCiN;
  logic               rspTimeout;

  logic               busy;

  modport master (
    input  cmdValid, cmdCiN, cmdValueA, cmdValueB,
    input  ciDone, ciResult, rspReady,
    output cmdReady, ciStart, ciN, ciValueA, ciValueB,
    output rspValid, rspResult, rspCiN, rspTimeout, busy
  );

  modport slave (
    output cmdValid, cmdCiN, cmdValueA, cmdValueB,
    output ciDone, ciResult, rspReady,
    input  cmdReady, ciStart, ciN, ciValueA, ciValueB,
    input  rspValid, rspResult, rspCiN, rspTimeout, busy
  );

endinterface

// File: rtl/ci_cmd_fifo.sv
// Synchronous FIFO of packed CI commands, full/empty flags.
// Pointers carry one wrap bit; storage has no reset.
module ci_cmd_fifo
  import ci_initiator_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  ci_cmd_t wdata,
  input  logic    pop,
  output ci_cmd_t rdata,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  ci_cmd_t     mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata   = mem[rptr[AW-1:0]];

  // storage write on accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  // pointer advance; simultaneous push/pop keeps the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/ci_initiator.sv
// CI protocol initiator: queued commands -> start pulse -> response.
// Optional counters: define CI_INITIATOR_STATS_EN.
module ci_initiator
  import ci_initiator_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clock,
  input  logic             nReset,
  ci_initiator_if.master   bus
`ifdef CI_INITIATOR_STATS_EN
  ,
  output logic [CNT_W-1:0] statIssued,
  output logic [CNT_W-1:0] statTimeouts,
  output logic [CNT_W-1:0] statSpurious
`endif
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  ci_cmd_t          cmd_in;
  ci_cmd_t          head;
  logic             full;
  logic             empty;
  logic             push;
  logic             issue_go;
  logic             to_hit;

  assign cmd_in   = {bus.cmdCiN, bus.cmdValueA, bus.cmdValueB};
  assign bus.cmdReady = nReset & ~full;
  assign push     = bus.cmdValid & bus.cmdReady;
  assign issue_go = (state == S_IDLE) & ~empty;
  assign to_hit   = TO_EN && (state == S_WAIT) &&
                    !bus.ciDone && (cnt == TO_LAST);
  assign bus.busy = (state != S_IDLE) | ~empty;

  ci_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst_n (nReset),
    .push  (push),
    .wdata (cmd_in),
    .pop   (issue_go),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // issue/wait/respond sequencing with registered bus outputs
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      bus.ciStart    <= 1'b0;
      bus.ciN        <= '0;
      bus.ciValueA   <= '0;
      bus.ciValueB   <= '0;
      bus.rspValid   <= 1'b0;
      bus.rspResult  <= '0;
      bus.rspCiN     <= '0;
      bus.rspTimeout <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (issue_go) begin
            bus.ciN      <= head.ci_n;
            bus.ciValueA <= head.value_a;
            bus.ciValueB <= head.value_b;
            bus.ciStart  <= 1'b1;
            cnt          <= '0;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          bus.ciStart <= 1'b0;
          if (bus.ciDone || to_hit) begin
            bus.rspValid   <= 1'b1;
            bus.rspResult  <= bus.ciDone ? bus.ciResult : '0;
            bus.rspTimeout <= ~bus.ciDone;
            bus.rspCiN     <= bus.ciN;
            bus.ciN        <= '0;
            bus.ciValueA   <= '0;
            bus.ciValueB   <= '0;
            state          <= S_RESPOND;
          end else begin
            if (state == S_WAIT && !(&cnt)) cnt <= cnt + CNT_W'(1);
            state <= S_WAIT;
          end
        end
        S_RESPOND: begin
          if (bus.rspReady) begin
            bus.rspValid   <= 1'b0;
            bus.rspResult  <= '0;
            bus.rspCiN     <= '0;
            bus.rspTimeout <= 1'b0;
            state          <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef CI_INITIATOR_STATS_EN
  logic spurious;

  assign spurious = bus.ciDone &&
                    (state == S_IDLE || state == S_RESPOND);

  // saturating event counters
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      statIssued   <= '0;
      statTimeouts <= '0;
      statSpurious <= '0;
    end else begin
      if (issue_go) statIssued   <= sat_inc(statIssued);
      if (to_hit)   statTimeouts <= sat_inc(statTimeouts);
      if (spurious) statSpurious <= sat_inc(statSpurious);
    end
  end
`endif

endmodule

// File: tb/tb_ci_initiator.sv
// Directed bench for ci_initiator: vector table plus corner sequences.
// Timeout parameter set to 8 to exercise the abort path.
module tb_ci_initiator;
  import ci_initiator_pkg::*;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] a;
    logic [31:0] b;
    int          mode;
    int          dly;
    logic [31:0] rv;
    logic [31:0] exp_res;
    logic        exp_to;
    int          exp_lat;
    int          exp_hold;
  } vec_t;

  logic clock;
  logic nReset;
  int   errors;
  int   checks;
  int   rmode;
  int   rdly;
  logic [31:0] rval;
  logic done_man;
  int   since;

  ci_initiator_if bus();

`ifdef CI_INITIATOR_STATS_EN
  logic [15:0] stat_issued;
  logic [15:0] stat_timeouts;
  logic [15:0] stat_spurious;
`endif

  ci_initiator #(
    .CMD_DEPTH      (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock  (clock),
    .nReset (nReset),
    .bus    (bus.master)
`ifdef CI_INITIATOR_STATS_EN
    ,
    .statIssued   (stat_issued),
    .statTimeouts (stat_timeouts),
    .statSpurious (stat_spurious)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] bytediff(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] n;
    n = 0;
    for (int k = 0; k < 4; k++)
      if (a[8*k +: 8] != b[8*k +: 8]) n = n + 1;
    return n;
  endfunction

  // cycles since start, cleared on done or response
  always @(posedge clock or negedge nReset) begin
    if (!nReset) since <= 0;
    else if (bus.ciDone) since <= 0;
    else if (bus.rspValid) since <= 0;
    else if (bus.ciStart) since <= 1;
    else if (since != 0) since <= since + 1;
  end

  // responder model: 0 none, 1 same-cycle, 2 delayed, 3 manual
  always_comb begin
    bus.ciDone   = 1'b0;
    bus.ciResult = 32'hBAD0_BAD0;
    case (rmode)
      1: if (bus.ciStart) begin
        bus.ciDone   = 1'b1;
        bus.ciResult = bytediff(bus.ciValueA, bus.ciValueB);
      end
      2: if (rdly != 0 && since == rdly) begin
        bus.ciDone   = 1'b1;
        bus.ciResult = rval;
      end
      3: bus.ciDone = done_man;
      default: ;
    endcase
  end

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    int hold;
    int bad;
    int starts;
    @(negedge clock);
    rmode = v.mode;
    rdly  = v.dly;
    rval  = v.rv;
    chk($sformatf("v%0d_cmd_ready", idx), 32'(bus.cmdReady), 1);
    bus.cmdValid  = 1'b1;
    bus.cmdCiN    = v.id;
    bus.cmdValueA = v.a;
    bus.cmdValueB = v.b;
    @(posedge clock);
    @(negedge clock);
    bus.cmdValid = 1'b0;
    n = 0; hold = 0; bad = 0; starts = 0;
    forever begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (bus.rspValid || n >= 40) break;
      if (bus.ciStart) starts++;
      if (bus.ciStart || since != 0) begin
        hold++;
        if (bus.ciN != v.id || bus.ciValueA != v.a ||
            bus.ciValueB != v.b) bad++;
      end
    end
    chk($sformatf("v%0d_latency", idx), 32'(n), 32'(v.exp_lat));
    chk($sformatf("v%0d_result", idx), bus.rspResult, v.exp_res);
    chk($sformatf("v%0d_timeout", idx), 32'(bus.rspTimeout),
        32'(v.exp_to));
    chk($sformatf("v%0d_rsp_ci_n", idx), 32'(bus.rspCiN),
        32'(v.id));
    chk($sformatf("v%0d_start_pulses", idx), 32'(starts), 1);
    chk($sformatf("v%0d_hold_cycles", idx), 32'(hold),
        32'(v.exp_hold));
    chk($sformatf("v%0d_hold_stable", idx), 32'(bad), 0);
    bus.rspReady = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.rspReady = 1'b0;
    rmode = 0;
    chk($sformatf("v%0d_rsp_drop", idx), 32'(bus.rspValid), 0);
    chk($sformatf("v%0d_ci_n_idle", idx), 32'(bus.ciN), 0);
    chk($sformatf("v%0d_busy_idle", idx), 32'(bus.busy), 0);
  endtask

  vec_t vecs [7];
  vec_t post;
  logic [7:0] got [$];
  int   accepted;
  logic rdy;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0;
    rmode = 0; rdly = 0; rval = 0; done_man = 1'b0;
    nReset = 1'b0;
    bus.cmdValid = 1'b0; bus.cmdCiN = '0;
    bus.cmdValueA = '0; bus.cmdValueB = '0;
    bus.rspReady = 1'b0;

    vecs[0] = '{8'h05, 32'h1122_3344, 32'h11AA_33BB, 1, 0, 32'h0,
                32'h2, 1'b0, 2, 1};
    vecs[1] = '{8'h06, 32'h0000_0000, 32'hFFFF_FFFF, 1, 0, 32'h0,
                32'h4, 1'b0, 2, 1};
    vecs[2] = '{8'h07, 32'h1234_5678, 32'h9ABC_DEF0, 2, 5,
                32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 7, 6};
    vecs[3] = '{8'h08, 32'hCAFE_0001, 32'h0, 0, 0, 32'h0,
                32'h0, 1'b1, 10, 9};
    vecs[4] = '{8'h09, 32'h1, 32'h2, 2, 8, 32'h0BAD_F00D,
                32'h0BAD_F00D, 1'b0, 10, 9};
    vecs[5] = '{8'h0A, 32'h3, 32'h4, 2, 1, 32'h0000_1234,
                32'h0000_1234, 1'b0, 3, 2};
    vecs[6] = '{8'h0B, 32'hAABB_CCDD, 32'hAABB_CCDD, 1, 0, 32'h0,
                32'h0, 1'b0, 2, 1};
    post    = '{8'h44, 32'h0102_0304, 32'h0102_0305, 1, 0, 32'h0,
                32'h1, 1'b0, 2, 1};

    #1;
    chk("rst_cmd_ready", 32'(bus.cmdReady), 0);
    chk("rst_ci_start", 32'(bus.ciStart), 0);
    chk("rst_rsp_valid", 32'(bus.rspValid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ci_n", 32'(bus.ciN), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    nReset = 1'b1;
    #1;
    chk("rel_cmd_ready", 32'(bus.cmdReady), 1);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // back-pressure: FIFO plus FSM hold five commands
    @(negedge clock);
    rmode = 1;
    accepted = 0;
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.cmdValid  = 1'b1;
      bus.cmdCiN    = 8'h21 + 8'(i);
      bus.cmdValueA = 32'(i);
      bus.cmdValueB = 32'h0;
      rdy = bus.cmdReady;
      @(posedge clock);
      if (rdy) accepted++;
      @(negedge clock);
    end
    bus.cmdValid = 1'b0;
    chk("bp_sixth_ready", 32'(rdy), 0);
    chk("bp_accepted", 32'(accepted), 5);
    chk("bp_rsp_first", 32'(bus.rspCiN), 32'h21);
    bus.rspReady = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus.rspValid) got.push_back(bus.rspCiN);
      @(posedge clock);
      @(negedge clock);
    end
    bus.rspReady = 1'b0;
    chk("bp_rsp_count", 32'(got.size()), 5);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("bp_order%0d", i), 32'(got[i]), 32'h21 + 32'(i));
    chk("bp_busy_end", 32'(bus.busy), 0);
    rmode = 0;

    // asynchronous reset in the middle of WAIT
    @(negedge clock);
    bus.cmdValid  = 1'b1;
    bus.cmdCiN    = 8'h33;
    bus.cmdValueA = 32'hA5A5_A5A5;
    bus.cmdValueB = 32'h5A5A_5A5A;
    @(posedge clock);
    @(negedge clock);
    bus.cmdValid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("mid_wait_ci_n", 32'(bus.ciN), 32'h33);
    nReset = 1'b0;
    #1;
    chk("arst_ci_n", 32'(bus.ciN), 0);
    chk("arst_value_a", bus.ciValueA, 0);
    chk("arst_value_b", bus.ciValueB, 0);
    chk("arst_ci_start", 32'(bus.ciStart), 0);
    chk("arst_rsp_valid", 32'(bus.rspValid), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_cmd_ready", 32'(bus.cmdReady), 0);
    @(posedge clock);
    @(negedge clock);
    nReset = 1'b1;
    #1;
    chk("arst_rel_ready", 32'(bus.cmdReady), 1);

    // spurious done while idle
    @(negedge clock);
    rmode = 3;
    done_man = 1'b1;
    @(posedge clock);
    @(negedge clock);
    done_man = 1'b0;
    rmode = 0;
    accepted = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.rspValid || bus.busy || bus.ciStart) accepted++;
      @(posedge clock);
      @(negedge clock);
    end
    chk("spur_no_activity", 32'(accepted), 0);
`ifdef CI_INITIATOR_STATS_EN
    chk("stat_spurious", 32'(stat_spurious), 1);
    chk("stat_issued", 32'(stat_issued), 0);
    chk("stat_timeouts", 32'(stat_timeouts), 0);
`endif

    run_vec(7, post);
`ifdef CI_INITIATOR_STATS_EN
    chk("stat_issued_post", 32'(stat_issued), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ci_initiator.md
Name: ci_initiator

Overview:
- Initiator side of the custom-instruction (CI) protocol (start / ciN / valueA / valueB -> done / result).
- Accepts queued CI commands from a producer (a DMA or pixel-streaming engine), issues each to the CI bus as a single start pulse, and waits for done, either in the same cycle or multi-cycle.
- Returns the captured result, or a timeout, on a valid/ready response port.
- Lets hardware engines drive pixel CIs (e.g. pixel-difference counting) without the CPU.

Parameters:
- CMD_DEPTH, 4, command FIFO depth; power of 2, at least 2.
- TIMEOUT_CYCLES, 255, WAIT cycles before abort; 0 = wait forever; max 65535.

Ports:
- clock  in  1  system clock
- nReset  in  1  asynchronous active-low reset
- cmdValid  in  1  command offered
- cmdReady  out  1  FIFO not full
- cmdCiN  in  8  target CI id
- cmdValueA  in  32  operand A
- cmdValueB  in  32  operand B
- ciStart  out  1  one-cycle start pulse
- ciN  out  8  CI id, held ISSUE..WAIT
- ciValueA  out  32  held ISSUE..WAIT
- ciValueB  out  32  held ISSUE..WAIT
- ciDone  in  1  responder done
- ciResult  in  32  valid only while ciDone=1
- rspValid  out  1  response available
- rspReady  in  1  consumer accepts
- rspResult  out  32  captured result; 0 on timeout
- rspCiN  out  8  id of the completed command
- rspTimeout  out  1  1 = aborted
- busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (asynchronous, nReset=0):
  - FIFO emptied; FSM goes to IDLE.
  - All outputs 0, except cmdReady=1 once nReset=1.
  - ciStart drops immediately, including mid-operation; the in-flight command is lost.
- Command handshake:
  - Push on cmdValid & cmdReady; cmdReady = !full. No bypass path.
  - Order preserved.
- FSM states IDLE, ISSUE, WAIT, RESPOND:
  - IDLE: if FIFO non-empty, pop and load ci* registers; next state ISSUE.
  - ISSUE: ciStart=1 for exactly this cycle; timeout counter cleared.
    - ciDone=1 this cycle: capture ciResult -> RESPOND (combinational responders).
    - Otherwise -> WAIT.
  - WAIT: ciStart=0; counter increments each cycle.
    - ciDone=1: capture -> RESPOND, rspTimeout=0.
    - Otherwise, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: RESPOND with rspResult=0, rspTimeout=1.
    - Done in the final timeout cycle wins: success, not timeout.
  - RESPOND: rspValid=1, with rsp* stable until rspReady; on handshake -> IDLE.
- ciN/ciValueA/ciValueB:
  - Registered; stable from ISSUE through the end of WAIT.
  - Cleared to 0 in IDLE so idle responders see no matching ciN.
- Latency and throughput:
  - Push into an empty idle block at edge E0 -> ciStart in the cycle after E1 -> rspValid after E2 for a same-cycle responder.
  - Peak throughput: one op per 3 cycles with rspReady=1.
- ciDone outside ISSUE/WAIT is spurious: ignored, no state change.
- Counter is 16 bits and never wraps (bounded by TIMEOUT_CYCLES); with TIMEOUT_CYCLES=0 it saturates and is unused.
- Push while the FSM pops in the same cycle is legal: FIFO count is unchanged.

Optional Feature:
- Macro CI_INITIATOR_STATS_EN.
- Defined: adds outputs statIssued, statTimeouts, statSpurious, each 16 bits.
  - Saturating counters.
  - Incremented on ISSUE entry, timeout exit, and ciDone outside ISSUE/WAIT respectively.
  - Reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package ci_initiator_pkg:
  - state enum.
  - CI id width constant (8) and data width constant (32).
  - Packed command struct {ciN, valueA, valueB}.
  - Counter width constant (16).
- Sub-module ci_cmd_fifo:
  - Parameterised synchronous FIFO on the packed command, with full/empty and async active-low reset.
- FSM, timeout logic and optional stats live in ci_initiator.

Test Plan:
1. Same-cycle responder (id 0x05, result = count of differing bytes); push {0x05, A=0x11223344, B=0x11AA33BB} -> one ciStart pulse, rspResult=2, rspTimeout=0, rspValid 2 edges after the push.
2. Responder raising done 5 cycles after start with 0xDEADBEEF -> ciStart high exactly 1 cycle, ciN/ciValueA/ciValueB constant for 6 cycles, rspResult=0xDEADBEEF, rspCiN matches.
3. TIMEOUT_CYCLES=8, no responder -> rspTimeout=1, rspResult=0 after 8 WAIT cycles; repeat with done in exactly the 8th WAIT cycle -> rspTimeout=0 and the result is captured.
4. rspReady=0, push 6 commands -> 5 accepted (4 queued + 1 in FSM), cmdReady=0 on the 6th; release rspReady -> responses in push order.
5. nReset pulsed low mid-WAIT -> all outputs 0 in the same cycle, busy=0; a new command afterwards completes normally.
6. ciDone pulsed while IDLE -> no response, state unchanged; with CI_INITIATOR_STATS_EN, statSpurious=1 and statIssued=0.
